// File: rtl/gray_pkg.sv
// Gray-code helpers and the overflow-mode type used by the gray counter.
package gray_pkg;

  localparam int MAX_WID = 32;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } count_mode_e;

  // Callers zero-extend narrower values to MAX_WID and truncate the result.
  // Zero upper bits leave the low bits' encoding unchanged in both directions.
  function automatic logic [MAX_WID-1:0] bin2gray(input logic [MAX_WID-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_WID-1:0] gray2bin(input logic [MAX_WID-1:0] gray);
    logic [MAX_WID-1:0] bin;
    bin = '0;
    bin[MAX_WID-1] = gray[MAX_WID-1];
    for (int i = MAX_WID-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter_gray2bin.sv
// Gray-to-binary converter for the counter's load path.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WID = 4
) (
  input  logic [WID-1:0] gray_i,
  output logic [WID-1:0] bin_o
);

  logic acc;

  always_comb begin
    bin_o = '0;
    acc   = gray_i[WID-1];
    bin_o[WID-1] = acc;
    for (int i = WID-2; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view, Gray-coded load,
// terminal-count flag and a one-cycle overflow pulse in wrap or saturate mode.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WID  = 4,
  parameter int WRAP = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  input  logic           up_i,
  input  logic           load_i,
  input  logic [WID-1:0] load_gray_i,
  output logic [WID-1:0] bin_o,
  output logic [WID-1:0] gray_o,
  output logic           tc_o,
  output logic           ovf_o
);

  localparam count_mode_e MODE = (WRAP != 0) ? MODE_WRAP : MODE_SAT;

  logic [WID-1:0] cnt_q, cnt_d;
  logic [WID-1:0] gray_q, gray_d;
  logic           ovf_q, ovf_d;
  logic [WID-1:0] loadBin;
  logic           atTerminal;

  gray2bin #(.WID(WID)) u_gray2bin (
    .gray_i (load_gray_i),
    .bin_o  (loadBin)
  );

  assign atTerminal = up_i ? (cnt_q == '1) : (cnt_q == '0);

  // Gray output is encoded from the same next state as the binary register,
  // so the two views can never disagree by a cycle.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (load_i) begin
      cnt_d = loadBin;
    end else if (en_i) begin
      ovf_d = atTerminal;
      if (!(atTerminal && MODE == MODE_SAT)) begin
        cnt_d = up_i ? (cnt_q + WID'(1)) : (cnt_q - WID'(1));
      end
    end
    gray_d = WID'(bin2gray(MAX_WID'(cnt_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bin_o  = cnt_q;
  assign gray_o = gray_q;
  assign tc_o   = atTerminal;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomized checks of gray_counter in wrap and saturate modes,
// at 4-bit and 6-bit widths.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, up, load;
  logic [3:0] loadGray4;
  logic [5:0] loadGray6;

  logic [3:0] wrapBin, wrapGray, satBin, satGray;
  logic       wrapTc, wrapOvf, satTc, satOvf;
  logic [5:0] wideBin, wideGray;
  logic       wideTc, wideOvf;

  int errors = 0;
  int checks = 0;

  logic [3:0] grayTab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_counter #(.WID(4), .WRAP(1)) dutWrap (
    .clk(clk), .reset(reset), .en_i(en), .up_i(up), .load_i(load),
    .load_gray_i(loadGray4), .bin_o(wrapBin), .gray_o(wrapGray),
    .tc_o(wrapTc), .ovf_o(wrapOvf));

  gray_counter #(.WID(4), .WRAP(0)) dutSat (
    .clk(clk), .reset(reset), .en_i(en), .up_i(up), .load_i(load),
    .load_gray_i(loadGray4), .bin_o(satBin), .gray_o(satGray),
    .tc_o(satTc), .ovf_o(satOvf));

  gray_counter #(.WID(6), .WRAP(1)) dutWide (
    .clk(clk), .reset(reset), .en_i(en), .up_i(up), .load_i(load),
    .load_gray_i(loadGray6), .bin_o(wideBin), .gray_o(wideGray),
    .tc_o(wideTc), .ovf_o(wideOvf));

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [3:0] g4);
    reset     = r;
    en        = e;
    up        = u;
    load      = l;
    loadGray4 = g4;
    loadGray6 = '0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] grayToBinModel(input logic [5:0] g);
    logic [5:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    return b;
  endfunction

  initial begin
    logic [3:0] prevGray;
    logic [5:0] model, prevWideGray;
    logic       modelOvf, modelTc, e, u, l;
    logic [5:0] g6;
    int         exp4, satExp;

    // Reset state, including tc following the direction input.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("reset_bin", 32'(wrapBin), 32'd0);
    checkOutput("reset_gray", 32'(wrapGray), 32'd0);
    checkOutput("reset_ovf", 32'(wrapOvf), 32'd0);
    checkOutput("reset_tc_up", 32'(wrapTc), 32'd0);
    checkOutput("reset_sat_bin", 32'(satBin), 32'd0);
    up = 1'b0;
    #1;
    checkOutput("reset_tc_down", 32'(wrapTc), 32'd1);

    // Wrap and saturate counting up over the top of the range.
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      exp4   = k % 16;
      satExp = (k >= 15) ? 15 : k;
      checkOutput("wrap_bin", 32'(wrapBin), 32'(exp4));
      checkOutput("wrap_gray", 32'(wrapGray), 32'(grayTab[exp4]));
      checkOutput("wrap_ovf", 32'(wrapOvf), (k == 16) ? 32'd1 : 32'd0);
      checkOutput("satup_bin", 32'(satBin), 32'(satExp));
      checkOutput("satup_gray", 32'(satGray), 32'(grayTab[satExp]));
      checkOutput("satup_ovf", 32'(satOvf), (k >= 16) ? 32'd1 : 32'd0);
      if (k == 15) checkOutput("wrap_tc_max", 32'(wrapTc), 32'd1);
    end

    // Counting down from zero: saturate holds and re-pulses, wrap rolls to max.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("satdn_bin", 32'(satBin), 32'd0);
      checkOutput("satdn_tc", 32'(satTc), 32'd1);
      checkOutput("satdn_ovf", 32'(satOvf), 32'd1);
      checkOutput("wrapdn_bin", 32'(wrapBin), 32'(16 - k));
      checkOutput("wrapdn_gray", 32'(wrapGray), 32'(grayTab[16 - k]));
      checkOutput("wrapdn_ovf", 32'(wrapOvf), (k == 1) ? 32'd1 : 32'd0);
    end

    // Reset together with load at cnt=12 wins and clears the pending pulse.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b1101);
    checkOutput("rstload_bin", 32'(wrapBin), 32'd0);
    checkOutput("rstload_gray", 32'(wrapGray), 32'd0);
    checkOutput("rstload_ovf", 32'(wrapOvf), 32'd0);
    checkOutput("rstload_tc", 32'(wrapTc), 32'd1);
    checkOutput("rstload_sat_ovf", 32'(satOvf), 32'd0);

    // Gray load overrides enable and never pulses ovf.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101);
    checkOutput("load_bin", 32'(wrapBin), 32'd9);
    checkOutput("load_gray", 32'(wrapGray), 32'hD);
    checkOutput("load_ovf", 32'(wrapOvf), 32'd0);
    checkOutput("load_sat_bin", 32'(satBin), 32'd9);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("postload_bin", 32'(wrapBin), 32'd10);
    checkOutput("postload_gray", 32'(wrapGray), 32'hF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000);
    checkOutput("loadmax_bin", 32'(wrapBin), 32'd15);
    checkOutput("loadmax_gray", 32'(wrapGray), 32'h8);
    checkOutput("loadmax_tc", 32'(wrapTc), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000);
    checkOutput("loadattc_bin", 32'(wrapBin), 32'd15);
    checkOutput("loadattc_ovf", 32'(wrapOvf), 32'd0);
    checkOutput("loadattc_sat_ovf", 32'(satOvf), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("afterload_wrap_bin", 32'(wrapBin), 32'd0);
    checkOutput("afterload_wrap_ovf", 32'(wrapOvf), 32'd1);
    checkOutput("afterload_sat_bin", 32'(satBin), 32'd15);
    checkOutput("afterload_sat_ovf", 32'(satOvf), 32'd1);

    // Direction flip at 5 takes effect immediately.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    prevGray = wrapGray;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("flipup_bin", 32'(wrapBin), 32'(k));
      checkOutput("flipup_onebit", 32'($countones(wrapGray ^ prevGray)), 32'd1);
      prevGray = wrapGray;
    end
    for (int k = 4; k >= 3; k--) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("flipdn_bin", 32'(wrapBin), 32'(k));
      checkOutput("flipdn_onebit", 32'($countones(wrapGray ^ prevGray)), 32'd1);
      prevGray = wrapGray;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("hold_bin", 32'(wrapBin), 32'd3);
    checkOutput("hold_ovf", 32'(wrapOvf), 32'd0);

    // Randomized 6-bit run against a reference model.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    model        = '0;
    prevWideGray = wideGray;
    for (int c = 0; c < 2000; c++) begin
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 15) == 0);
      g6 = 6'($urandom);
      reset = 1'b0; en = e; up = u; load = l; loadGray6 = g6;
      #1;
      modelTc = u ? (model == 6'h3F) : (model == 6'h00);
      checkOutput("rand_tc", 32'(wideTc), 32'(modelTc));
      modelOvf = 1'b0;
      if (l) begin
        model = grayToBinModel(g6);
      end else if (e) begin
        modelOvf = modelTc;
        model    = u ? model + 6'd1 : model - 6'd1;
      end
      @(posedge clk);
      #1;
      checkOutput("rand_bin", 32'(wideBin), 32'(model));
      checkOutput("rand_gray", 32'(wideGray), 32'(model ^ (model >> 1)));
      checkOutput("rand_ovf", 32'(wideOvf), 32'(modelOvf));
      if (!l) begin
        checkOutput("rand_onebit",
                    32'($countones(wideGray ^ prevWideGray) <= 1), 32'd1);
      end
      prevWideGray = wideGray;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WID, default 4, meaning the counter width in bits; legal range is 2..32.
REQ-002 SHALL have parameter WRAP, default 1, meaning the overflow mode: 1 = wrap around, 0 = saturate at the end of range.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en_i, input, 1 bit: count enable.
REQ-006 SHALL have port up_i, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-007 SHALL have port load_i, input, 1 bit: load request.
REQ-008 SHALL have port load_gray_i, input, WID bits: the load value, supplied in Gray code.
REQ-009 SHALL have port bin_o, output, WID bits: the registered count in binary.
REQ-010 SHALL have port gray_o, output, WID bits: the registered count in reflected-binary Gray code.
REQ-011 SHALL have port tc_o, output, 1 bit: terminal count, combinational from state and up_i.
REQ-012 SHALL have port ovf_o, output, 1 bit: registered one-cycle pulse on overflow or underflow.

Function
REQ-013 SHALL hold one binary state register cnt_q; bin_o = cnt_q.
REQ-014 SHALL register gray_o from the same next-state value as cnt_q, so that gray_o == cnt_q ^ (cnt_q >> 1) on every cycle.
REQ-015 SHALL apply the priority reset > load_i > en_i; with none of these asserted, state holds.
REQ-016 On load_i: SHALL convert load_gray_i to binary via prefix-XOR (b[WID-1] = g[WID-1]; b[i] = b[i+1] ^ g[i]) and load it; the value is visible on both outputs the next cycle.
REQ-017 On load_i: SHALL ignore en_i in that cycle and SHALL NOT pulse ovf_o.
REQ-018 On en_i with up_i=1: SHALL increment cnt_q; with up_i=0, SHALL decrement it.
REQ-019 SHALL drive tc_o = 1 when (up_i && cnt_q == 2^WID-1) or (!up_i && cnt_q == 0); otherwise 0.
REQ-020 On en_i && tc_o with WRAP=1: SHALL step cnt_q modulo 2^WID (max->0 going up, 0->max going down).
REQ-021 On en_i && tc_o with WRAP=0: SHALL hold cnt_q unchanged.
REQ-022 On en_i && tc_o in either mode: SHALL assert ovf_o for exactly the next cycle.
REQ-023 Continuous counting: ovf_o SHALL re-pulse on every enabled cycle while tc_o stays high (saturate mode).
REQ-024 SHALL change gray_o in at most one bit per cycle, except on load or reset.
REQ-025 Direction change: up_i SHALL take effect in the same cycle it is sampled, with no bubble.

Reset
REQ-026 On reset=1 at a rising edge: cnt_q, bin_o, gray_o and ovf_o SHALL become 0, overriding load_i and en_i.
REQ-027 tc_o after reset SHALL follow REQ-019: 1 if up_i=0, else 0.
REQ-028 Reset asserted mid-count SHALL take effect at the next edge, with no residual ovf_o pulse.

Structure
REQ-029 Package gray_pkg SHALL hold the bin2gray and gray2bin functions (parameterised by width) and a count-mode enum {MODE_SAT, MODE_WRAP}.
REQ-030 SHALL instantiate one sub-module, gray2bin (parameter WID), for the load-path conversion; the Gray encoding of the next state uses the package function.
REQ-031 SHALL contain no latches and no clock gating.

Verification
REQ-032 Wrap up: WID=4, WRAP=1, reset, then en_i=1, up_i=1 for 17 cycles -> gray_o steps 0000,0001,0011,...,1000 then 0000; ovf_o pulses once, one cycle after cnt=15.
REQ-033 Saturate down: WRAP=0, reset, en_i=1, up_i=0 -> tc_o=1, bin_o stays 0, ovf_o high every cycle after the first.
REQ-034 Load: load_i=1, load_gray_i=4'b1101 with en_i=1 -> next cycle bin_o=9, gray_o=1101, ovf_o=0; the following counting-up cycle gives bin_o=10, gray_o=1111.
REQ-035 Direction flip: count up to 5, then set up_i=0 -> bin_o sequence 5,4,3; gray_o is one-bit-distance on every step.
REQ-036 Reset mid-operation: assert reset and load_i together at cnt=12 -> next cycle all outputs 0, ovf_o=0.
REQ-037 Exhaustive check: WID=6, random en_i/up_i/load_i for 2000 cycles -> scoreboard matches bin_o/gray_o every cycle, and the one-bit-change property holds.
